// File: rtl/gbm_path_stepper_if.sv
// gbm_path_stepper_if: run control, normal-sample stream and
// result stream for the multi-path GBM stepper.
interface gbm_path_stepper_if #(
  parameter int WIDTH     = 32,
  parameter int NUM_PATHS = 8,
  parameter int NUM_STEPS = 16
);
  localparam int PW = $clog2(NUM_PATHS);
  localparam int SW = $clog2(NUM_STEPS) + 1;

  logic                    start;
  logic                    mode;
  logic signed [WIDTH-1:0] s0;
  logic signed [WIDTH-1:0] mu_dt;
  logic signed [WIDTH-1:0] vol_sqrt_dt;
  logic                    z_valid;
  logic                    z_ready;
  logic signed [WIDTH-1:0] z;
  logic                    valid_out;
  logic                    ready_in;
  logic signed [WIDTH-1:0] s_out;
  logic [PW-1:0]           path_out;
  logic [SW-1:0]           step_out;
  logic                    last_out;
  logic                    busy;
  logic                    done;

  modport master (
    output start, mode, s0, mu_dt, vol_sqrt_dt,
    output z_valid, z, ready_in,
    input  z_ready, valid_out, s_out,
    input  path_out, step_out, last_out,
    input  busy, done
  );

  modport slave (
    input  start, mode, s0, mu_dt, vol_sqrt_dt,
    input  z_valid, z, ready_in,
    output z_ready, valid_out, s_out,
    output path_out, step_out, last_out,
    output busy, done
  );
endinterface

// File: rtl/gbm_path_stepper.sv
// gbm_path_stepper: advances NUM_PATHS GBM path states NUM_STEPS times
// from a streamed normal z; Euler price (mode 0) or log-price (mode 1).
module gbm_path_stepper #(
  parameter int WIDTH     = 32,
  parameter int QFRAC     = 16,
  parameter int NUM_PATHS = 8,
  parameter int NUM_STEPS = 16
) (
  input logic              clk,
  input logic              rst,
  gbm_path_stepper_if.slave bus_if
);
  localparam int PW   = $clog2(NUM_PATHS);
  localparam int SW   = $clog2(NUM_STEPS) + 1;
  localparam int GW   = WIDTH + 2;
  localparam int DW   = 2 * WIDTH;
  localparam int PRW  = WIDTH + GW;
  localparam int SUMW = PRW + 1;

  localparam logic [PW-1:0] P_LAST = PW'(NUM_PATHS - 1);
  localparam logic [SW-1:0] S_LAST = SW'(NUM_STEPS);

  localparam logic signed [DW-1:0] GMAX =
    {{(DW-GW+1){1'b0}}, {(GW-1){1'b1}}};
  localparam logic signed [DW-1:0] GMIN =
    {{(DW-GW+1){1'b1}}, {(GW-1){1'b0}}};

  localparam logic signed [WIDTH-1:0] WMAX =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] WMIN =
    {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [SUMW-1:0] WMAX_S = SUMW'(WMAX);
  localparam logic signed [SUMW-1:0] WMIN_S = SUMW'(WMIN);

  if (NUM_PATHS < 4) begin : g_np_chk
    $error("NUM_PATHS must be >= 4");
  end
  if (NUM_STEPS < 1) begin : g_ns_chk
    $error("NUM_STEPS must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic                    mode_q;
  logic signed [WIDTH-1:0] s0_q;
  logic signed [WIDTH-1:0] mu_q;
  logic signed [WIDTH-1:0] vol_q;

  logic [PW-1:0] init_q;
  logic [PW-1:0] path_q;
  logic [SW-1:0] step_q;

  logic signed [WIDTH-1:0] ram [NUM_PATHS];

  logic                    v0_q;
  logic signed [WIDTH-1:0] z0_q;
  logic signed [WIDTH-1:0] x0_q;
  logic [PW-1:0]           p0_q;
  logic [SW-1:0]           k0_q;
  logic                    l0_q;

  logic                    v1_q;
  logic signed [WIDTH-1:0] x1_q;
  logic signed [GW-1:0]    inc1_q;
  logic [PW-1:0]           p1_q;
  logic [SW-1:0]           k1_q;
  logic                    l1_q;

  logic                    vout_q;
  logic signed [WIDTH-1:0] sout_q;
  logic [PW-1:0]           pout_q;
  logic [SW-1:0]           kout_q;
  logic                    lout_q;

  logic adv;
  logic z_ready;
  logic z_acc;
  logic last_iss;

  logic signed [DW-1:0]    vz_full;
  logic signed [DW-1:0]    vz_sh;
  logic signed [DW-1:0]    inc_wide;
  logic signed [GW-1:0]    inc1_d;
  logic signed [PRW-1:0]   prod;
  logic signed [PRW-1:0]   prod_sh;
  logic signed [SUMW-1:0]  addend;
  logic signed [SUMW-1:0]  sum;
  logic signed [WIDTH-1:0] res_d;

  assign adv      = !vout_q || bus_if.ready_in;
  assign z_ready  = (state_q == RUN) && adv;
  assign z_acc    = bus_if.z_valid && z_ready;
  assign last_iss = (path_q == P_LAST) && (step_q == S_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus_if.start) state_d = INIT;
      INIT:  if (init_q == P_LAST) state_d = RUN;
      RUN:   if (z_acc && last_iss) state_d = DRAIN;
      DRAIN: begin
        if (vout_q && bus_if.ready_in && lout_q)
          state_d = DONE;
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // S1: drift plus diffusion, held at WIDTH+2 guard bits
  always_comb begin
    vz_full  = DW'(vol_q) * DW'(z0_q);
    vz_sh    = vz_full >>> QFRAC;
    inc_wide = vz_sh + DW'(mu_q);
    inc1_d   = inc_wide[GW-1:0];
    if (inc_wide > GMAX)
      inc1_d = GMAX[GW-1:0];
    else if (inc_wide < GMIN)
      inc1_d = GMIN[GW-1:0];
  end

  // S2: Euler adds S*inc, log mode adds inc directly
  always_comb begin
    prod    = PRW'(x1_q) * PRW'(inc1_q);
    prod_sh = prod >>> QFRAC;
    addend  = mode_q ? SUMW'(inc1_q) : SUMW'(prod_sh);
    sum     = SUMW'(x1_q) + addend;
    res_d   = sum[WIDTH-1:0];
    if (sum > WMAX_S)
      res_d = WMAX;
    else if (!mode_q && sum[SUMW-1])
      res_d = '0;
    else if (sum < WMIN_S)
      res_d = WMIN;
  end

  always_ff @(posedge clk) begin
    if (state_q == INIT)
      ram[init_q] <= s0_q;
    else if (adv && v1_q)
      ram[p1_q] <= res_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      s0_q    <= '0;
      mu_q    <= '0;
      vol_q   <= '0;
      init_q  <= '0;
      path_q  <= '0;
      step_q  <= '0;
      v0_q    <= 1'b0;
      z0_q    <= '0;
      x0_q    <= '0;
      p0_q    <= '0;
      k0_q    <= '0;
      l0_q    <= 1'b0;
      v1_q    <= 1'b0;
      x1_q    <= '0;
      inc1_q  <= '0;
      p1_q    <= '0;
      k1_q    <= '0;
      l1_q    <= 1'b0;
      vout_q  <= 1'b0;
      sout_q  <= '0;
      pout_q  <= '0;
      kout_q  <= '0;
      lout_q  <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_q == IDLE && bus_if.start) begin
        mode_q <= bus_if.mode;
        s0_q   <= bus_if.s0;
        mu_q   <= bus_if.mu_dt;
        vol_q  <= bus_if.vol_sqrt_dt;
        init_q <= '0;
        path_q <= '0;
        step_q <= SW'(1);
      end

      if (state_q == INIT)
        init_q <= init_q + PW'(1);

      if (z_acc) begin
        if (path_q == P_LAST) begin
          path_q <= '0;
          step_q <= step_q + SW'(1);
        end else begin
          path_q <= path_q + PW'(1);
        end
      end

      if (adv) begin
        v0_q <= z_acc;
        if (z_acc) begin
          z0_q <= bus_if.z;
          x0_q <= ram[path_q];
          p0_q <= path_q;
          k0_q <= step_q;
          l0_q <= last_iss;
        end

        v1_q <= v0_q;
        if (v0_q) begin
          x1_q   <= x0_q;
          inc1_q <= inc1_d;
          p1_q   <= p0_q;
          k1_q   <= k0_q;
          l1_q   <= l0_q;
        end

        vout_q <= v1_q;
        if (v1_q) begin
          sout_q <= res_d;
          pout_q <= p1_q;
          kout_q <= k1_q;
          lout_q <= l1_q;
        end
      end
    end
  end

  assign bus_if.z_ready   = z_ready;
  assign bus_if.valid_out = vout_q;
  assign bus_if.s_out     = sout_q;
  assign bus_if.path_out  = pout_q;
  assign bus_if.step_out  = kout_q;
  assign bus_if.last_out  = lout_q;
  assign bus_if.busy      = (state_q != IDLE);
  assign bus_if.done      = (state_q == DONE);
endmodule

// File: tb/tb_gbm_path_stepper.sv
// tb_gbm_path_stepper: directed runs of the GBM stepper with 4 paths
// and 2 steps against hand-computed results.
module tb_gbm_path_stepper;
  localparam int W  = 32;
  localparam int Q  = 16;
  localparam int NP = 4;
  localparam int NS = 2;
  localparam int NOUT = NP * NS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  gbm_path_stepper_if #(
    .WIDTH(W), .NUM_PATHS(NP), .NUM_STEPS(NS)
  ) bus ();

  gbm_path_stepper #(
    .WIDTH(W), .QFRAC(Q), .NUM_PATHS(NP), .NUM_STEPS(NS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus_if(bus)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.start       = 1'b0;
    bus.mode        = 1'b0;
    bus.s0          = '0;
    bus.mu_dt       = '0;
    bus.vol_sqrt_dt = '0;
    bus.z_valid     = 1'b0;
    bus.z           = '0;
    bus.ready_in    = 1'b1;
  endtask

  task automatic run_case(
    input string       nm,
    input logic        md,
    input logic [31:0] s0v,
    input logic [31:0] muv,
    input logic [31:0] volv,
    input logic [31:0] zv,
    input logic [31:0] e1,
    input logic [31:0] e2,
    input int          st_at,
    input int          st_len
  );
    int cyc = 0;
    int outs = 0;
    int acc = 0;
    int f_acc = -1;
    int f_val = -1;
    int last_hs = -1;
    int done_cnt = 0;
    int done_cyc = -1;
    int st_left = 0;
    bit stalled = 1'b0;
    logic [31:0] exp_s;
    logic [1:0]  exp_p;
    logic [1:0]  exp_k;
    logic        exp_l;
    logic [31:0] sn_s;
    logic [1:0]  sn_p;
    logic [1:0]  sn_k;
    logic        sn_l;

    @(negedge clk);
    bus.mode        = md;
    bus.s0          = s0v;
    bus.mu_dt       = muv;
    bus.vol_sqrt_dt = volv;
    bus.z           = zv;
    bus.z_valid     = 1'b1;
    bus.ready_in    = 1'b1;
    bus.start       = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;

    while (cyc < 200 && !(last_hs >= 0 && cyc >= last_hs + 2)) begin
      if (st_len > 0 && !stalled && outs == st_at && bus.valid_out) begin
        stalled = 1'b1;
        st_left = st_len;
        sn_s = bus.s_out;
        sn_p = bus.path_out;
        sn_k = bus.step_out;
        sn_l = bus.last_out;
      end
      bus.ready_in = (st_left == 0);
      #1;
      if (st_left > 0) begin
        n_assert++;
        if (bus.z_ready !== 1'b0 || bus.valid_out !== 1'b1) begin
          n_fail++;
          $display("FAIL %s stall_ctl: z_ready=%b valid_out=%b, want 0 1",
                   nm, bus.z_ready, bus.valid_out);
        end
        if (st_left < st_len) begin
          n_assert++;
          if (bus.s_out !== sn_s || bus.path_out !== sn_p ||
              bus.step_out !== sn_k || bus.last_out !== sn_l) begin
            n_fail++;
            $display("FAIL %s stall_hold: got s=%h p=%0d k=%0d l=%b, want s=%h p=%0d k=%0d l=%b",
                     nm, bus.s_out, bus.path_out, bus.step_out, bus.last_out,
                     sn_s, sn_p, sn_k, sn_l);
          end
        end
        st_left--;
      end
      if (bus.z_valid && bus.z_ready) begin
        acc++;
        if (f_acc < 0) f_acc = cyc;
      end
      if (bus.valid_out && f_val < 0) f_val = cyc;
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.valid_out && bus.ready_in) begin
        exp_s = (outs < NP) ? e1 : e2;
        exp_p = 2'(outs % NP);
        exp_k = 2'(outs / NP + 1);
        exp_l = (outs == NOUT - 1);
        n_assert++;
        if (bus.s_out !== exp_s || bus.path_out !== exp_p ||
            bus.step_out !== exp_k || bus.last_out !== exp_l) begin
          n_fail++;
          $display("FAIL %s out%0d: got s=%h p=%0d k=%0d l=%b, want s=%h p=%0d k=%0d l=%b",
                   nm, outs, bus.s_out, bus.path_out, bus.step_out,
                   bus.last_out, exp_s, exp_p, exp_k, exp_l);
        end
        outs++;
        if (outs == NOUT) last_hs = cyc;
      end
      @(negedge clk);
      cyc++;
    end

    n_assert++;
    if (last_hs < 0) begin
      n_fail++;
      $display("FAIL %s timeout: outputs=%0d, want %0d within 200 cycles",
               nm, outs, NOUT);
    end else begin
      if (done_cnt != 1 || done_cyc != last_hs + 1) begin
        n_fail++;
        $display("FAIL %s done_pulse: count=%0d at cycle %0d, want 1 at cycle %0d",
                 nm, done_cnt, done_cyc, last_hs + 1);
      end
      n_assert++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.valid_out !== 1'b0) begin
        n_fail++;
        $display("FAIL %s end_idle: busy=%b done=%b valid=%b, want 0 0 0",
                 nm, bus.busy, bus.done, bus.valid_out);
      end
      n_assert++;
      if (acc != NOUT) begin
        n_fail++;
        $display("FAIL %s z_count: got %0d, want %0d", nm, acc, NOUT);
      end
      if (st_len == 0) begin
        n_assert++;
        if (f_val - f_acc != 3) begin
          n_fail++;
          $display("FAIL %s latency: got %0d, want 3", nm, f_val - f_acc);
        end
      end
    end
    bus.z_valid  = 1'b0;
    bus.ready_in = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_assert++;
    if (bus.valid_out !== 1'b0 || bus.z_ready !== 1'b0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.last_out !== 1'b0 ||
        bus.s_out !== 32'h0 || bus.path_out !== 2'd0 ||
        bus.step_out !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: v=%b zr=%b busy=%b done=%b l=%b s=%h p=%0d k=%0d, want all 0",
               bus.valid_out, bus.z_ready, bus.busy, bus.done,
               bus.last_out, bus.s_out, bus.path_out, bus.step_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_flat_euler();
    run_case("flat_euler", 1'b0, 32'h0064_0000, 32'd0, 32'd0, 32'd0,
             32'h0064_0000, 32'h0064_0000, 0, 0);
  endtask

  task automatic test_euler_drift();
    longint t1;
    logic [31:0] e2;
    t1 = 64'sd6619100;
    e2 = 32'(t1 + ((t1 * 64'sd655) >>> 16));
    run_case("euler_drift", 1'b0, 32'h0064_0000, 32'd655, 32'd0, 32'd0,
             32'h0064_FFDC, e2, 0, 0);
  endtask

  task automatic test_log_drift();
    run_case("log_drift", 1'b1, 32'd0, 32'd0, 32'd32768, 32'd65536,
             32'd32768, 32'd65536, 0, 0);
  endtask

  task automatic test_stall();
    run_case("stall", 1'b0, 32'h0064_0000, 32'd0, 32'd0, 32'd0,
             32'h0064_0000, 32'h0064_0000, 3, 5);
  endtask

  task automatic test_saturation();
    run_case("sat_euler_floor", 1'b0, 32'h0064_0000, 32'd0, 32'd32768,
             32'hFFF8_0000, 32'd0, 32'd0, 0, 0);
    run_case("sat_log_ceiling", 1'b1, 32'h7FFF_0000, 32'h0010_0000,
             32'd0, 32'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 0);
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    bus.mode        = 1'b0;
    bus.s0          = 32'h0064_0000;
    bus.mu_dt       = '0;
    bus.vol_sqrt_dt = '0;
    bus.z           = '0;
    bus.z_valid     = 1'b1;
    bus.start       = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    n_assert++;
    if (bus.busy !== 1'b1 || bus.valid_out !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_active: busy=%b valid=%b, want 1 1",
               bus.busy, bus.valid_out);
    end
    rst = 1'b1;
    @(negedge clk);
    n_assert++;
    if (bus.valid_out !== 1'b0 || bus.z_ready !== 1'b0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.last_out !== 1'b0 ||
        bus.s_out !== 32'h0 || bus.path_out !== 2'd0 ||
        bus.step_out !== 2'd0) begin
      n_fail++;
      $display("FAIL midrun_reset: v=%b zr=%b busy=%b done=%b l=%b s=%h p=%0d k=%0d, want all 0",
               bus.valid_out, bus.z_ready, bus.busy, bus.done,
               bus.last_out, bus.s_out, bus.path_out, bus.step_out);
    end
    bus.z_valid = 1'b0;
    rst = 1'b0;
    run_case("after_reset", 1'b0, 32'h0064_0000, 32'd0, 32'd0, 32'd0,
             32'h0064_0000, 32'h0064_0000, 0, 0);
  endtask

  initial begin
    test_reset();
    test_flat_euler();
    test_euler_drift();
    test_log_drift();
    test_stall();
    test_saturation();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
